fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage that feeds the decode stage. Its IF/ID register supplies the instruction word whose [6:0] bits drive the control decoder. It owns the fetch PC, issues one request at a time to instruction memory over a req/ready handshake, and honours stall and flush from downstream. It stops fetching after a HALT instruction (opcode 7'b1111111).

Parameters:
PC_W, 9, width of byte-address PC; arithmetic is modulo 2^PC_W
INSTR_W, 32, instruction width
RESET_PC, 0, fetch address after reset; bits [1:0] must be 0

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
imem_req  output  1  fetch request; high in FETCH and DRAIN
imem_addr  output  PC_W  request address, driven from fetch_pc
imem_rdata  input  INSTR_W  instruction; valid only when imem_ready=1
imem_ready  input  1  response strobe; completes the outstanding request
stall_i  input  1  decode cannot accept; hold IF/ID
flush_i  input  1  redirect (taken branch/jal/jalr); highest priority
redirect_pc_i  input  PC_W  target when flush_i=1; bits [1:0] ignored (forced 0)
if_id_instr  output  INSTR_W  instruction to decode
if_id_pc  output  PC_W  address of if_id_instr
if_id_valid  output  1  if_id_instr is a real instruction (0 = bubble)
halted  output  1  high while in state HALTED

Behaviour:
- Reset (async, rst_n=0): state=FETCH, fetch_pc=RESET_PC, if_id_valid=0, if_id_instr=0, if_id_pc=0, hold buffer empty, halted=0. imem_req goes high the first cycle after rst_n rises.
- Handshake: at most one request outstanding. imem_req and imem_addr stay stable until a cycle with imem_ready=1. The response is consumed in that cycle.
- States: FETCH, HOLD, DRAIN, HALTED. Priority is flush > stall > normal.
- FETCH, no ready: wait; IF/ID holds if stall_i=1, else if_id_valid<=0.
- FETCH, ready, no stall/flush: if_id_instr<=imem_rdata, if_id_pc<=fetch_pc, if_id_valid<=1, fetch_pc<=fetch_pc+4. Next state is HALTED if imem_rdata[6:0]==7'b1111111, else FETCH. This gives one instruction per cycle with a zero-wait memory.
- FETCH, ready, stall_i=1: capture imem_rdata/fetch_pc into the hold buffer, fetch_pc+=4, go to HOLD, IF/ID unchanged, imem_req=0.
- HOLD, stall_i=1: hold everything.
- HOLD, stall_i=0: load the buffer into IF/ID with valid=1. Go to HALTED if the buffered opcode is HALT, else FETCH.
- Flush in FETCH without ready: IF/ID valid<=0, save target, go to DRAIN. imem_req stays high to the old address.
- Flush in FETCH with ready the same cycle: drop the response, fetch_pc<=target, stay in FETCH, IF/ID valid<=0.
- DRAIN: wait for imem_ready, discard the data, fetch_pc<=saved target, go to FETCH. A new flush in DRAIN overwrites the saved target. IF/ID valid=0 throughout.
- Flush in HOLD or HALTED: discard the buffer, fetch_pc<=target, go to FETCH, IF/ID valid<=0, halted clears next cycle.
- Flush overrides a simultaneous stall_i: IF/ID is invalidated even while stalled.
- HALTED: imem_req=0. IF/ID keeps the HALT instruction while stall_i=1, then becomes a bubble. Only flush or reset leaves this state.
- Wrap-around: fetch_pc+4 overflows modulo 2^PC_W (e.g. 9'h1FC -> 9'h000).
- Reset mid-request: abandons the outstanding request immediately. Memory must tolerate the dropped req.

Test Plan:
- Reset, RESET_PC=0, zero-wait memory returning 0x00000013 -> imem_addr 0,4,8,… on consecutive cycles; if_id_valid=1 from the 2nd cycle after reset with if_id_pc tracking.
- Ready with stall_i=1 for 3 cycles, rdata=0x00A00093 at addr 8 -> IF/ID holds its previous value and imem_req=0. On release IF/ID=0x00A00093/pc 8, and the next request is addr 12.
- 2-wait-state memory, flush_i with redirect 0x040 while waiting on addr 0x010 -> imem_req stays high on 0x010 until ready, the data is discarded, the next request is 0x040, and if_id_valid=0 throughout.
- Memory returns 0x0000007F at addr 0x014 -> IF/ID gets the HALT, halted=1 next cycle, and imem_req stays 0. A later flush to 0x000 resumes fetch there.
- Start at fetch_pc 0x1FC -> the next request is 0x000.
- Assert rst_n=0 mid-DRAIN -> all outputs return to reset values asynchronously, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues one imem request at a time and feeds the IF/ID register.
// Stall holds IF/ID (parking a late response in a one-entry buffer); flush redirects and drains any in-flight request.
module fetch_unit #(
  parameter int              PC_W     = 9,
  parameter int              INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ready,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic [PC_W-1:0]    redirect_pc_i,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc,
  output logic               if_id_valid,
  output logic               halted
);

  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DRAIN, S_HALTED} state_t;

  localparam logic [6:0] HALT_OP = 7'b1111111;

  state_t               state_q, state_d;
  logic [PC_W-1:0]      fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]      tgt_q, tgt_d;
  logic [INSTR_W-1:0]   buf_instr_q, buf_instr_d;
  logic [PC_W-1:0]      buf_pc_q, buf_pc_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic                 valid_q, valid_d;

  logic [PC_W-1:0]      target;
  logic [PC_W-1:0]      pc_inc;

  assign target = redirect_pc_i & ~PC_W'(3);
  assign pc_inc = fetch_pc_q + PC_W'(4);

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    tgt_d       = tgt_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    instr_d     = instr_q;
    pc_d        = pc_q;
    valid_d     = valid_q;

    case (state_q)
      S_FETCH: begin
        if (flush_i) begin
          valid_d = 1'b0;
          if (imem_ready) begin
            fetch_pc_d = target;
          end else begin
            // The old request must still complete before the new address goes out.
            tgt_d   = target;
            state_d = S_DRAIN;
          end
        end else if (imem_ready) begin
          fetch_pc_d = pc_inc;
          if (stall_i) begin
            buf_instr_d = imem_rdata;
            buf_pc_d    = fetch_pc_q;
            state_d     = S_HOLD;
          end else begin
            instr_d = imem_rdata;
            pc_d    = fetch_pc_q;
            valid_d = 1'b1;
            state_d = (imem_rdata[6:0] == HALT_OP) ? S_HALTED : S_FETCH;
          end
        end else if (!stall_i) begin
          valid_d = 1'b0;
        end
      end

      S_HOLD: begin
        if (flush_i) begin
          valid_d    = 1'b0;
          fetch_pc_d = target;
          state_d    = S_FETCH;
        end else if (!stall_i) begin
          instr_d = buf_instr_q;
          pc_d    = buf_pc_q;
          valid_d = 1'b1;
          state_d = (buf_instr_q[6:0] == HALT_OP) ? S_HALTED : S_FETCH;
        end
      end

      S_DRAIN: begin
        valid_d = 1'b0;
        if (flush_i) tgt_d = target;
        if (imem_ready) begin
          fetch_pc_d = flush_i ? target : tgt_q;
          state_d    = S_FETCH;
        end
      end

      S_HALTED: begin
        if (flush_i) begin
          valid_d    = 1'b0;
          fetch_pc_d = target;
          state_d    = S_FETCH;
        end else if (!stall_i) begin
          valid_d = 1'b0;
        end
      end

      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      fetch_pc_q  <= RESET_PC;
      tgt_q       <= '0;
      buf_instr_q <= '0;
      buf_pc_q    <= '0;
      instr_q     <= '0;
      pc_q        <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      tgt_q       <= tgt_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      instr_q     <= instr_d;
      pc_q        <= pc_d;
      valid_q     <= valid_d;
    end
  end

  assign imem_req    = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign imem_addr   = fetch_pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc    = pc_q;
  assign if_id_valid = valid_q;
  assign halted      = (state_q == S_HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a wait-state memory model and an in-order scoreboard of IF/ID deliveries.
module tb_fetch_unit;
  localparam int PC_W    = 9;
  localparam int INSTR_W = 32;

  logic               clk;
  logic               rst_n;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               imem_ready;
  logic               stall_i;
  logic               flush_i;
  logic [PC_W-1:0]    redirect_pc_i;
  logic [INSTR_W-1:0] if_id_instr;
  logic [PC_W-1:0]    if_id_pc;
  logic               if_id_valid;
  logic               halted;

  fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC('0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_ready    (imem_ready),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .redirect_pc_i (redirect_pc_i),
    .if_id_instr   (if_id_instr),
    .if_id_pc      (if_id_pc),
    .if_id_valid   (if_id_valid),
    .halted        (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: answers after wait_cfg idle cycles of a held request.
  logic [INSTR_W-1:0] mem [0:127];
  int wait_cfg;
  int wcnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wcnt <= 0;
    else if (imem_req && !imem_ready) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  assign imem_ready = imem_req && (wcnt >= wait_cfg);
  assign imem_rdata = mem[imem_addr[8:2]];

  int checks;
  int errors;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } exp_t;

  exp_t sb_q[$];

  task automatic push(input logic [INSTR_W-1:0] instr, input logic [PC_W-1:0] pc);
    exp_t e;
    e.instr = instr;
    e.pc    = pc;
    sb_q.push_back(e);
  endtask

  // An edge taken without stall leaves a fresh IF/ID value; if valid it must be the next expected entry.
  logic stall_s;
  always @(posedge clk) begin
    exp_t e;
    stall_s = stall_i;
    #1;
    if (rst_n && !stall_s && if_id_valid) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_pc", {55'd0, if_id_pc}, 64'h1_0000);
      end else begin
        e = sb_q.pop_front();
        chk("sb_instr", {32'd0, if_id_instr}, {32'd0, e.instr});
        chk("sb_pc", {55'd0, if_id_pc}, {55'd0, e.pc});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_bus(input string tag, input logic req, input logic [PC_W-1:0] addr,
                         input logic valid);
    chk({tag, "_req"}, {63'd0, imem_req}, {63'd0, req});
    if (req) chk({tag, "_addr"}, {55'd0, imem_addr}, {55'd0, addr});
    chk({tag, "_valid"}, {63'd0, if_id_valid}, {63'd0, valid});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 128; i++) mem[i] = 32'h0000_0013;
    mem[2] = 32'h00A0_0093;
    mem[5] = 32'h0000_007F;
    wait_cfg      = 0;
    rst_n         = 1'b0;
    stall_i       = 1'b0;
    flush_i       = 1'b0;
    redirect_pc_i = '0;

    // Reset values
    #1;
    chk("rst_valid", {63'd0, if_id_valid}, 64'd0);
    chk("rst_instr", {32'd0, if_id_instr}, 64'd0);
    chk("rst_pc", {55'd0, if_id_pc}, 64'd0);
    chk("rst_halted", {63'd0, halted}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Zero-wait streaming
    chk_bus("t1_c1", 1'b1, 9'h000, 1'b0);
    push(32'h13, 9'h000);
    step();
    chk_bus("t1_c2", 1'b1, 9'h004, 1'b1);
    push(32'h13, 9'h004);
    step();
    chk_bus("t1_c3", 1'b1, 9'h008, 1'b1);

    // Response arrives while decode is stalled
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_req", {63'd0, imem_req}, 64'd0);
      chk("t2_hold_pc", {55'd0, if_id_pc}, 64'h004);
      chk("t2_hold_instr", {32'd0, if_id_instr}, 64'h13);
    end
    push(32'h00A0_0093, 9'h008);
    stall_i = 1'b0;
    step();
    chk_bus("t2_rel", 1'b1, 9'h00C, 1'b1);
    chk("t2_rel_pc", {55'd0, if_id_pc}, 64'h008);

    // Flush while waiting on a slow response
    push(32'h13, 9'h00C);
    step();
    chk_bus("t3_pre", 1'b1, 9'h010, 1'b1);
    wait_cfg      = 2;
    flush_i       = 1'b1;
    redirect_pc_i = 9'h043;
    step();
    flush_i = 1'b0;
    chk_bus("t3_d1", 1'b1, 9'h010, 1'b0);
    step();
    chk_bus("t3_d2", 1'b1, 9'h010, 1'b0);
    step();
    chk_bus("t3_new", 1'b1, 9'h040, 1'b0);
    wait_cfg = 0;

    // Flush coinciding with a ready response, landing on a HALT
    flush_i       = 1'b1;
    redirect_pc_i = 9'h014;
    step();
    flush_i = 1'b0;
    chk_bus("t4_redir", 1'b1, 9'h014, 1'b0);
    push(32'h0000_007F, 9'h014);
    step();
    chk("t4_halted", {63'd0, halted}, 64'd1);
    chk("t4_req", {63'd0, imem_req}, 64'd0);
    chk("t4_instr", {32'd0, if_id_instr}, 64'h7F);
    step();
    chk("t4_halted2", {63'd0, halted}, 64'd1);
    chk_bus("t4_bubble", 1'b0, 9'h000, 1'b0);
    step();
    chk_bus("t4_idle", 1'b0, 9'h000, 1'b0);
    flush_i       = 1'b1;
    redirect_pc_i = 9'h000;
    step();
    flush_i = 1'b0;
    chk("t4_unhalt", {63'd0, halted}, 64'd0);
    chk_bus("t4_resume", 1'b1, 9'h000, 1'b0);

    // PC wrap-around
    flush_i       = 1'b1;
    redirect_pc_i = 9'h1FC;
    step();
    flush_i = 1'b0;
    chk_bus("t5_top", 1'b1, 9'h1FC, 1'b0);
    push(32'h13, 9'h1FC);
    step();
    chk_bus("t5_wrap", 1'b1, 9'h000, 1'b1);
    push(32'h13, 9'h000);
    step();
    chk_bus("t5_next", 1'b1, 9'h004, 1'b1);

    // Asynchronous reset in the middle of a drain
    wait_cfg      = 3;
    flush_i       = 1'b1;
    redirect_pc_i = 9'h100;
    step();
    flush_i = 1'b0;
    step();
    chk_bus("t6_drain", 1'b1, 9'h004, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_addr", {55'd0, imem_addr}, 64'h000);
    chk("t6_rst_valid", {63'd0, if_id_valid}, 64'd0);
    chk("t6_rst_instr", {32'd0, if_id_instr}, 64'd0);
    chk("t6_rst_pc", {55'd0, if_id_pc}, 64'd0);
    chk("t6_rst_halted", {63'd0, halted}, 64'd0);
    wait_cfg = 0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_bus("t6_restart", 1'b1, 9'h000, 1'b0);
    push(32'h13, 9'h000);
    step();
    chk_bus("t6_next", 1'b1, 9'h004, 1'b1);

    chk("sb_leftover", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
